router_slave_wr_1to2: RTL and testbench

- Write-path router that takes the single slave-side AXI3 write port produced by router_master_2to1 and fans it out to two slaves by address decode.
- Routes AW by address and steers W beats in AW-acceptance order through a target FIFO.
- Merges the two B channels back to the master side with a round-robin arbiter and a registered output stage.
- Tracks outstanding writes per slave per ID so that same-ID responses cannot return out of order.

---
 rtl/router_slave_wr_1to2_pkg.sv | 27 ++
 rtl/route_fifo_sync.sv | 62 ++++++
 rtl/router_slave_wr_1to2_chk.sv | 16 +
 rtl/router_slave_wr_1to2.sv | 266 ++++++++++++++++++++++++++
 tb/tb_router_slave_wr_1to2.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_slave_wr_1to2_pkg.sv
// Shared definitions for the 1-to-2 AXI3 write router.
// Holds the AXI3 field widths, the slave-select encoding and small decode helpers.
package router_slave_wr_1to2_pkg;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int RESP_W = 2;

    // Slave-select encoding, used in the W target FIFO and the B arbiter.
    localparam logic SEL_S1 = 1'b0;
    localparam logic SEL_S2 = 1'b1;

    // Address decode: a match under the mask selects slave 2, anything else slave 1.
    function automatic logic decode_sel(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] mask,
                                        input logic [ADDR_W-1:0] base);
        return ((addr & mask) == (base & mask)) ? SEL_S2 : SEL_S1;
    endfunction

    function automatic logic other_sel(input logic sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/route_fifo_sync.sv
// Generic synchronous FIFO used to remember W-beat targets in AW order.
// Ports: clk/rst (async active-high), push/push_data, pop/pop_data, empty, full.
// Push while full and pop while empty are ignored. DEPTH must be a power of 2 (>= 2).
module route_fifo_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign empty     = (count_r == '0);
    assign full      = (count_r == DEPTH_C);
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/router_slave_wr_1to2_chk.sv
// Simulation checker for the write router's response bookkeeping.
// Ports: clk/rst, b_hs (a slave B accepted), b_cnt_zero (its per-ID counter is 0),
// total_zero (the total outstanding counter is 0).
module router_slave_wr_1to2_chk (
    input logic clk,
    input logic rst,
    input logic b_hs,
    input logic b_cnt_zero,
    input logic total_zero
);

    // A response must match an outstanding write; otherwise the counter saturates at 0.
    a_b_has_outstanding_id: assert property (@(posedge clk) disable iff (rst) b_hs |-> !b_cnt_zero);
    a_b_has_outstanding_total: assert property (@(posedge clk) disable iff (rst) b_hs |-> !total_zero);

endmodule

// File: rtl/router_slave_wr_1to2.sv
// AXI3 write-path router: one master-side port fanned out to two slaves.
// Ports: aclk/areset; master AW/W inputs with awready_m/wready_m, master B outputs
// (registered) with bready_m; per-slave AW/W outputs and B inputs with _s1/_s2 suffixes.
// AW routes by address decode, W follows AW acceptance order via a target FIFO, and the
// two B channels merge through a round-robin arbiter into an output register.
module router_slave_wr_1to2
    import router_slave_wr_1to2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SEL_MASK        = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] S2_BASE         = 32'h8000_0000,
    parameter int                MAX_OUTSTANDING = 4,
    parameter int                WFIFO_DEPTH     = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] awaddr_m,
    input  logic [ID_W-1:0]   awid_m,
    input  logic [1:0]        awburst_m,
    input  logic [LEN_W-1:0]  awlen_m,
    input  logic [2:0]        awsize_m,
    input  logic [1:0]        awlock_m,
    input  logic [3:0]        awcache_m,
    input  logic [2:0]        awprot_m,
    input  logic              awvalid_m,
    output logic              awready_m,
    input  logic [ID_W-1:0]   wid_m,
    input  logic [DATA_W-1:0] wdata_m,
    input  logic [STRB_W-1:0] wstrb_m,
    input  logic              wlast_m,
    input  logic              wvalid_m,
    output logic              wready_m,
    output logic [ID_W-1:0]   bid_m,
    output logic [RESP_W-1:0] bresp_m,
    output logic              bvalid_m,
    input  logic              bready_m,
    output logic [ADDR_W-1:0] awaddr_s1,
    output logic [ID_W-1:0]   awid_s1,
    output logic [1:0]        awburst_s1,
    output logic [LEN_W-1:0]  awlen_s1,
    output logic [2:0]        awsize_s1,
    output logic [1:0]        awlock_s1,
    output logic [3:0]        awcache_s1,
    output logic [2:0]        awprot_s1,
    output logic              awvalid_s1,
    input  logic              awready_s1,
    output logic [ADDR_W-1:0] awaddr_s2,
    output logic [ID_W-1:0]   awid_s2,
    output logic [1:0]        awburst_s2,
    output logic [LEN_W-1:0]  awlen_s2,
    output logic [2:0]        awsize_s2,
    output logic [1:0]        awlock_s2,
    output logic [3:0]        awcache_s2,
    output logic [2:0]        awprot_s2,
    output logic              awvalid_s2,
    input  logic              awready_s2,
    output logic [ID_W-1:0]   wid_s1,
    output logic [DATA_W-1:0] wdata_s1,
    output logic [STRB_W-1:0] wstrb_s1,
    output logic              wlast_s1,
    output logic              wvalid_s1,
    input  logic              wready_s1,
    output logic [ID_W-1:0]   wid_s2,
    output logic [DATA_W-1:0] wdata_s2,
    output logic [STRB_W-1:0] wstrb_s2,
    output logic              wlast_s2,
    output logic              wvalid_s2,
    input  logic              wready_s2,
    input  logic [ID_W-1:0]   bid_s1,
    input  logic [RESP_W-1:0] bresp_s1,
    input  logic              bvalid_s1,
    output logic              bready_s1,
    input  logic [ID_W-1:0]   bid_s2,
    input  logic [RESP_W-1:0] bresp_s2,
    input  logic              bvalid_s2,
    output logic              bready_s2
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int IDX_W   = 1 + ID_W;           // {slave, id}
    localparam int NUM_CNT = 2 * (2 ** ID_W);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_CNT-1:0] VEC_ONE = {{(NUM_CNT-1){1'b0}}, 1'b1};

    logic               run_s;
    logic               tgt_s;
    logic               other_busy_s;
    logic               stall_s;
    logic               aw_hs_s;
    logic               head_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               w_pop_s;
    logic               can_load_s;
    logic               gnt_valid_s;
    logic               gnt_s;
    logic [ID_W-1:0]    gnt_bid_s;
    logic [RESP_W-1:0]  gnt_bresp_s;
    logic               b_hs_s;
    logic [NUM_CNT-1:0] inc_vec_s;
    logic [NUM_CNT-1:0] dec_vec_s;
    logic               b_cnt_zero_s;
    logic               total_zero_s;
    logic [CNT_W-1:0]   cnt_r [NUM_CNT];
    logic [CNT_W-1:0]   total_r;
    logic               bvalid_r;
    logic [ID_W-1:0]    bid_r;
    logic [RESP_W-1:0]  bresp_r;
    logic               prio_r;

    // While reset is asserted every handshake output is forced low.
    assign run_s = ~areset;

    assign awaddr_s1  = awaddr_m;   assign awaddr_s2  = awaddr_m;
    assign awid_s1    = awid_m;     assign awid_s2    = awid_m;
    assign awburst_s1 = awburst_m;  assign awburst_s2 = awburst_m;
    assign awlen_s1   = awlen_m;    assign awlen_s2   = awlen_m;
    assign awsize_s1  = awsize_m;   assign awsize_s2  = awsize_m;
    assign awlock_s1  = awlock_m;   assign awlock_s2  = awlock_m;
    assign awcache_s1 = awcache_m;  assign awcache_s2 = awcache_m;
    assign awprot_s1  = awprot_m;   assign awprot_s2  = awprot_m;
    assign wid_s1     = wid_m;      assign wid_s2     = wid_m;
    assign wdata_s1   = wdata_m;    assign wdata_s2   = wdata_m;
    assign wstrb_s1   = wstrb_m;    assign wstrb_s2   = wstrb_m;
    assign wlast_s1   = wlast_m;    assign wlast_s2   = wlast_m;

    assign bvalid_m = bvalid_r;
    assign bid_m    = bid_r;
    assign bresp_m  = bresp_r;

    // AW decode and stall: an ID still outstanding at the other slave blocks the AW,
    // which keeps same-ID responses in order.
    always_comb begin
        tgt_s        = decode_sel(awaddr_m, SEL_MASK, S2_BASE);
        other_busy_s = (cnt_r[{other_sel(tgt_s), awid_m}] != '0);
        stall_s      = (total_r == MAX_C) | fifo_full_s | other_busy_s;
        awvalid_s1   = 1'b0;
        awvalid_s2   = 1'b0;
        awready_m    = 1'b0;
        if (run_s && !stall_s) begin
            if (tgt_s == SEL_S2) begin
                awvalid_s2 = awvalid_m;
                awready_m  = awready_s2;
            end else begin
                awvalid_s1 = awvalid_m;
                awready_m  = awready_s1;
            end
        end else begin
            awvalid_s1 = 1'b0;
            awvalid_s2 = 1'b0;
            awready_m  = 1'b0;
        end
    end

    assign aw_hs_s = awvalid_m & awready_m;

    // W steering by the FIFO head; an empty FIFO (also the reset state) blocks W.
    always_comb begin
        wvalid_s1 = 1'b0;
        wvalid_s2 = 1'b0;
        wready_m  = 1'b0;
        if (!fifo_empty_s) begin
            if (head_s == SEL_S2) begin
                wvalid_s2 = wvalid_m;
                wready_m  = wready_s2;
            end else begin
                wvalid_s1 = wvalid_m;
                wready_m  = wready_s1;
            end
        end else begin
            wready_m = 1'b0;
        end
    end

    assign w_pop_s = wvalid_m & wready_m & wlast_m;

    route_fifo_sync #(
        .WIDTH (1),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (aw_hs_s),
        .push_data (tgt_s),
        .pop       (w_pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Round-robin B grant; prio_r names the slave that wins a tie.
    always_comb begin
        can_load_s  = run_s & (~bvalid_r | bready_m);
        gnt_valid_s = 1'b0;
        gnt_s       = SEL_S1;
        case ({bvalid_s2, bvalid_s1})
            2'b01: begin gnt_valid_s = 1'b1; gnt_s = SEL_S1; end
            2'b10: begin gnt_valid_s = 1'b1; gnt_s = SEL_S2; end
            2'b11: begin gnt_valid_s = 1'b1; gnt_s = prio_r; end
            default: begin gnt_valid_s = 1'b0; gnt_s = SEL_S1; end
        endcase
        gnt_bid_s   = (gnt_s == SEL_S2) ? bid_s2 : bid_s1;
        gnt_bresp_s = (gnt_s == SEL_S2) ? bresp_s2 : bresp_s1;
        b_hs_s      = can_load_s & gnt_valid_s;
        bready_s1   = b_hs_s & (gnt_s == SEL_S1);
        bready_s2   = b_hs_s & (gnt_s == SEL_S2);
    end

    assign inc_vec_s    = aw_hs_s ? (VEC_ONE << {tgt_s, awid_m}) : '0;
    assign dec_vec_s    = b_hs_s ? (VEC_ONE << {gnt_s, gnt_bid_s}) : '0;
    assign b_cnt_zero_s = (cnt_r[{gnt_s, gnt_bid_s}] == '0);
    assign total_zero_s = (total_r == '0);

    // Per-slave per-ID outstanding counters; inc+dec nets to zero, dec saturates at 0.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_r <= '{default: '0};
        end else begin
            for (int e = 0; e < NUM_CNT; e++) begin
                if (inc_vec_s[e[IDX_W-1:0]] && !dec_vec_s[e[IDX_W-1:0]]) begin
                    cnt_r[e[IDX_W-1:0]] <= cnt_r[e[IDX_W-1:0]] + CNT_ONE;
                end else if (dec_vec_s[e[IDX_W-1:0]] && !inc_vec_s[e[IDX_W-1:0]] &&
                             (cnt_r[e[IDX_W-1:0]] != '0)) begin
                    cnt_r[e[IDX_W-1:0]] <= cnt_r[e[IDX_W-1:0]] - CNT_ONE;
                end
            end
        end
    end

    // Total outstanding counter with the same net/saturate rules.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            total_r <= '0;
        end else if (aw_hs_s && !b_hs_s) begin
            total_r <= total_r + CNT_ONE;
        end else if (b_hs_s && !aw_hs_s && (total_r != '0)) begin
            total_r <= total_r - CNT_ONE;
        end
    end

    // B output register: loads the winner, else empties once the master takes it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bvalid_r <= 1'b0;
            bid_r    <= '0;
            bresp_r  <= '0;
            prio_r   <= SEL_S1;
        end else if (b_hs_s) begin
            bvalid_r <= 1'b1;
            bid_r    <= gnt_bid_s;
            bresp_r  <= gnt_bresp_s;
            prio_r   <= other_sel(gnt_s);
        end else if (bready_m) begin
            bvalid_r <= 1'b0;
        end
    end

    router_slave_wr_1to2_chk u_chk (
        .clk        (aclk),
        .rst        (areset),
        .b_hs       (b_hs_s),
        .b_cnt_zero (b_cnt_zero_s),
        .total_zero (total_zero_s)
    );

endmodule

// File: tb/tb_router_slave_wr_1to2.sv
module tb_router_slave_wr_1to2;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr_m;  logic [3:0] awid_m;  logic [1:0] awburst_m;  logic [3:0] awlen_m;
    logic [2:0]  awsize_m;  logic [1:0] awlock_m; logic [3:0] awcache_m; logic [2:0] awprot_m;
    logic        awvalid_m, awready_m;
    logic [3:0]  wid_m;     logic [31:0] wdata_m; logic [3:0] wstrb_m;   logic wlast_m;
    logic        wvalid_m, wready_m;
    logic [3:0]  bid_m;     logic [1:0] bresp_m;  logic bvalid_m, bready_m;
    logic [31:0] awaddr_s1, awaddr_s2; logic [3:0] awid_s1, awid_s2;
    logic [1:0]  awburst_s1, awburst_s2; logic [3:0] awlen_s1, awlen_s2;
    logic [2:0]  awsize_s1, awsize_s2;   logic [1:0] awlock_s1, awlock_s2;
    logic [3:0]  awcache_s1, awcache_s2; logic [2:0] awprot_s1, awprot_s2;
    logic        awvalid_s1, awvalid_s2, awready_s1, awready_s2;
    logic [3:0]  wid_s1, wid_s2; logic [31:0] wdata_s1, wdata_s2; logic [3:0] wstrb_s1, wstrb_s2;
    logic        wlast_s1, wlast_s2, wvalid_s1, wvalid_s2, wready_s1, wready_s2;
    logic [3:0]  bid_s1, bid_s2; logic [1:0] bresp_s1, bresp_s2;
    logic        bvalid_s1, bvalid_s2, bready_s1, bready_s2;

    router_slave_wr_1to2 dut (
        .aclk(aclk), .areset(areset),
        .awaddr_m(awaddr_m), .awid_m(awid_m), .awburst_m(awburst_m), .awlen_m(awlen_m),
        .awsize_m(awsize_m), .awlock_m(awlock_m), .awcache_m(awcache_m), .awprot_m(awprot_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
        .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .awaddr_s1(awaddr_s1), .awid_s1(awid_s1), .awburst_s1(awburst_s1), .awlen_s1(awlen_s1),
        .awsize_s1(awsize_s1), .awlock_s1(awlock_s1), .awcache_s1(awcache_s1), .awprot_s1(awprot_s1),
        .awvalid_s1(awvalid_s1), .awready_s1(awready_s1),
        .awaddr_s2(awaddr_s2), .awid_s2(awid_s2), .awburst_s2(awburst_s2), .awlen_s2(awlen_s2),
        .awsize_s2(awsize_s2), .awlock_s2(awlock_s2), .awcache_s2(awcache_s2), .awprot_s2(awprot_s2),
        .awvalid_s2(awvalid_s2), .awready_s2(awready_s2),
        .wid_s1(wid_s1), .wdata_s1(wdata_s1), .wstrb_s1(wstrb_s1), .wlast_s1(wlast_s1),
        .wvalid_s1(wvalid_s1), .wready_s1(wready_s1),
        .wid_s2(wid_s2), .wdata_s2(wdata_s2), .wstrb_s2(wstrb_s2), .wlast_s2(wlast_s2),
        .wvalid_s2(wvalid_s2), .wready_s2(wready_s2),
        .bid_s1(bid_s1), .bresp_s1(bresp_s1), .bvalid_s1(bvalid_s1), .bready_s1(bready_s1),
        .bid_s2(bid_s2), .bresp_s2(bresp_s2), .bvalid_s2(bvalid_s2), .bready_s2(bready_s2)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Reference model: queued W targets, outstanding counts, B register and RR priority.
    int       m_q[$];
    int       m_cnt[2][16];
    int       m_tot;
    int       m_prio;
    bit       m_bv;
    logic [3:0] m_bid;
    logic [1:0] m_bresp;
    // Bench-side master burst tracker and slave response queues.
    int         pend_len[$];
    int         mbeat;
    logic [3:0] sq1[$];
    logic [3:0] sq2[$];
    // Per-cycle results of eval(), consumed by advance().
    int  e_tgt, e_g;
    bit  e_aw_hs, e_w_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_q.delete(); pend_len.delete(); sq1.delete(); sq2.delete();
        for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) m_cnt[s][i] = 0;
        m_tot = 0; m_prio = 0; m_bv = 1'b0; m_bid = 4'd0; m_bresp = 2'd0; mbeat = 0;
    endtask

    task automatic idle();
        awvalid_m = 1'b0; awaddr_m = 32'd0; awid_m = 4'd0; awburst_m = 2'd1; awlen_m = 4'd0;
        awsize_m = 3'd2; awlock_m = 2'd0; awcache_m = 4'd0; awprot_m = 3'd0;
        wvalid_m = 1'b0; wid_m = 4'd0; wdata_m = 32'd0; wstrb_m = 4'hF; wlast_m = 1'b0;
        bready_m = 1'b1; awready_s1 = 1'b0; awready_s2 = 1'b0; wready_s1 = 1'b0; wready_s2 = 1'b0;
        bvalid_s1 = 1'b0; bvalid_s2 = 1'b0; bid_s1 = 4'd0; bid_s2 = 4'd0; bresp_s1 = 2'd0; bresp_s2 = 2'd0;
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic eval();
        bit stall, e_awr, e_wr, can;
        int head;
        e_tgt = ((awaddr_m & 32'h8000_0000) == 32'h8000_0000) ? 1 : 0;
        stall = (m_tot == 4) || (m_q.size() == 4) || (m_cnt[1 - e_tgt][awid_m] != 0);
        e_awr = !stall && ((e_tgt == 1) ? awready_s2 : awready_s1);
        chk("awvalid_s1", 32'(awvalid_s1), 32'(awvalid_m && !stall && e_tgt == 0));
        chk("awvalid_s2", 32'(awvalid_s2), 32'(awvalid_m && !stall && e_tgt == 1));
        chk("awready_m", 32'(awready_m), 32'(e_awr));
        chk("awaddr_s2", awaddr_s2, awaddr_m);
        head = (m_q.size() == 0) ? -1 : m_q[0];
        e_wr = (head == 0) ? wready_s1 : ((head == 1) ? wready_s2 : 1'b0);
        chk("wvalid_s1", 32'(wvalid_s1), 32'(head == 0 && wvalid_m));
        chk("wvalid_s2", 32'(wvalid_s2), 32'(head == 1 && wvalid_m));
        chk("wready_m", 32'(wready_m), 32'(e_wr));
        chk("wdata_s1", wdata_s1, wdata_m);
        can = !m_bv || bready_m;
        e_g = -1;
        if (can) begin
            if (bvalid_s1 && bvalid_s2) e_g = m_prio;
            else if (bvalid_s1) e_g = 0;
            else if (bvalid_s2) e_g = 1;
        end
        chk("bready_s1", 32'(bready_s1), 32'(e_g == 0));
        chk("bready_s2", 32'(bready_s2), 32'(e_g == 1));
        chk("bvalid_m", 32'(bvalid_m), 32'(m_bv));
        if (m_bv) begin
            chk("bid_m", 32'(bid_m), 32'(m_bid));
            chk("bresp_m", 32'(bresp_m), 32'(m_bresp));
        end
        e_aw_hs = awvalid_m && e_awr;
        e_w_hs  = wvalid_m && e_wr;
    endtask

    // Apply this cycle's handshakes to the model, then move to just after the next edge.
    task automatic advance();
        logic [3:0] gid;
        if (e_w_hs) begin
            mbeat++;
            if (wlast_m) begin
                void'(m_q.pop_front());
                if (pend_len.size() > 0) void'(pend_len.pop_front());
                mbeat = 0;
            end
        end
        if (e_aw_hs) begin
            m_q.push_back(e_tgt);
            pend_len.push_back(int'(awlen_m));
            if (e_tgt == 1) sq2.push_back(awid_m); else sq1.push_back(awid_m);
            m_cnt[e_tgt][awid_m]++;
            m_tot++;
        end
        if (e_g >= 0) begin
            gid = (e_g == 1) ? bid_s2 : bid_s1;
            if (m_cnt[e_g][gid] > 0) m_cnt[e_g][gid]--;
            if (m_tot > 0) m_tot--;
            m_bv = 1'b1; m_bid = gid; m_bresp = (e_g == 1) ? bresp_s2 : bresp_s1;
            m_prio = 1 - e_g;
            if (e_g == 1) void'(sq2.pop_front()); else void'(sq1.pop_front());
        end else if (bready_m) begin
            m_bv = 1'b0;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic step();
        #2;
        eval();
        advance();
    endtask

    task automatic drive_random();
        awvalid_m = 1'($urandom_range(0, 1));
        awaddr_m  = $urandom();
        awid_m    = 4'($urandom_range(0, 3));
        awlen_m   = 4'($urandom_range(0, 3));
        awprot_m  = 3'($urandom_range(0, 7));
        awready_s1 = ($urandom_range(0, 9) < 7);
        awready_s2 = ($urandom_range(0, 9) < 7);
        wvalid_m  = 1'($urandom_range(0, 1));
        wdata_m   = $urandom();
        wid_m     = 4'($urandom_range(0, 15));
        wlast_m   = (pend_len.size() > 0) ? (mbeat == pend_len[0]) : 1'($urandom_range(0, 1));
        wready_s1 = ($urandom_range(0, 9) < 7);
        wready_s2 = ($urandom_range(0, 9) < 7);
        bvalid_s1 = (sq1.size() > 0) && ($urandom_range(0, 2) != 0);
        bid_s1    = (sq1.size() > 0) ? sq1[0] : 4'd0;
        bresp_s1  = 2'($urandom_range(0, 3));
        bvalid_s2 = (sq2.size() > 0) && ($urandom_range(0, 2) != 0);
        bid_s2    = (sq2.size() > 0) ? sq2[0] : 4'd0;
        bresp_s2  = 2'($urandom_range(0, 3));
        bready_m  = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle();
        reset_model();
        areset = 1'b1;
        awvalid_m = 1'b1; awready_s1 = 1'b1; bvalid_s1 = 1'b1;
        #2;
        chk("rst_awvalid_s1", 32'(awvalid_s1), 32'd0);
        chk("rst_awready_m", 32'(awready_m), 32'd0);
        chk("rst_bready_s1", 32'(bready_s1), 32'd0);
        chk("rst_bvalid_m", 32'(bvalid_m), 32'd0);
        chk("rst_bid_m", 32'(bid_m), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        idle();
        areset = 1'b0;

        // One AW to slave 1, four beats, then its B.
        awvalid_m = 1'b1; awaddr_m = 32'h0000_1000; awid_m = 4'd3; awlen_m = 4'd3; awready_s1 = 1'b1;
        #2;
        chk("d1_awvalid_s1", 32'(awvalid_s1), 32'd1);
        chk("d1_awvalid_s2", 32'(awvalid_s2), 32'd0);
        eval(); advance();
        idle();
        for (int b = 0; b < 4; b++) begin
            wvalid_m = 1'b1; wready_s1 = 1'b1; wlast_m = (b == 3); wdata_m = 32'hA000 + 32'(b);
            #2;
            chk("d1_wvalid_s1", 32'(wvalid_s1), 32'd1);
            chk("d1_wlast_s1", 32'(wlast_s1), 32'(b == 3));
            eval(); advance();
        end
        idle();
        wvalid_m = 1'b1; wready_s1 = 1'b1;
        #2;
        chk("d1_fifo_empty_wready", 32'(wready_m), 32'd0);
        eval(); advance();
        idle();
        bvalid_s1 = 1'b1; bid_s1 = 4'd3; bresp_s1 = 2'd0;
        step();
        idle();
        #2;
        chk("d1_bvalid_m", 32'(bvalid_m), 32'd1);
        chk("d1_bid_m", 32'(bid_m), 32'd3);
        eval(); advance();

        // Fill MAX_OUTSTANDING, drain W, fifth AW waits for one B.
        for (int i = 0; i < 4; i++) begin
            idle();
            awvalid_m = 1'b1; awaddr_m = 32'h100 * 32'(i); awid_m = 4'(i); awready_s1 = 1'b1;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            wvalid_m = 1'b1; wlast_m = 1'b1; wready_s1 = 1'b1;
            step();
        end
        idle();
        awvalid_m = 1'b1; awaddr_m = 32'h500; awid_m = 4'd4; awready_s1 = 1'b1;
        #2;
        chk("d2_fifth_stalled", 32'(awready_m), 32'd0);
        eval(); advance();
        bvalid_s1 = 1'b1; bid_s1 = 4'd0;
        #2;
        chk("d2_stall_during_b", 32'(awready_m), 32'd0);
        eval(); advance();
        bvalid_s1 = 1'b0;
        #2;
        chk("d2_fifth_accepted", 32'(awready_m), 32'd1);
        eval(); advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            step();
        end

        // Reset in the middle of a burst to slave 2.
        idle();
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        reset_model();
        awvalid_m = 1'b1; awaddr_m = 32'h8000_0010; awid_m = 4'd6; awlen_m = 4'd3; awready_s2 = 1'b1;
        step();
        idle();
        for (int b = 0; b < 2; b++) begin
            wvalid_m = 1'b1; wready_s2 = 1'b1; wlast_m = 1'b0;
            step();
        end
        wvalid_m = 1'b1; wready_s2 = 1'b1; bvalid_s2 = 1'b1; bid_s2 = 4'd6;
        awvalid_m = 1'b1; awaddr_m = 32'h8000_0000; awready_s2 = 1'b1;
        #2;
        areset = 1'b1;
        #1;
        chk("mr_wvalid_s2", 32'(wvalid_s2), 32'd0);
        chk("mr_wready_m", 32'(wready_m), 32'd0);
        chk("mr_awvalid_s2", 32'(awvalid_s2), 32'd0);
        chk("mr_awready_m", 32'(awready_m), 32'd0);
        chk("mr_bready_s2", 32'(bready_s2), 32'd0);
        @(posedge aclk); #1;
        idle();
        areset = 1'b0;
        reset_model();
        awvalid_m = 1'b1; awaddr_m = 32'h8000_0020; awid_m = 4'd9; awlen_m = 4'd1; awready_s2 = 1'b1;
        #2;
        chk("pr_awvalid_s2", 32'(awvalid_s2), 32'd1);
        eval(); advance();
        idle();
        for (int b = 0; b < 2; b++) begin
            wvalid_m = 1'b1; wready_s2 = 1'b1; wlast_m = (b == 1);
            #2;
            chk("pr_wvalid_s2", 32'(wvalid_s2), 32'd1);
            eval(); advance();
        end
        idle();
        bvalid_s2 = 1'b1; bid_s2 = 4'd9; bresp_s2 = 2'd2;
        step();
        idle();
        #2;
        chk("pr_bvalid_m", 32'(bvalid_m), 32'd1);
        chk("pr_bid_m", 32'(bid_m), 32'd9);
        chk("pr_bresp_m", 32'(bresp_m), 32'd2);
        eval(); advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
